instruction_memory_loader: RTL

- Writer-side counterpart to the instruction fetch path.
- Receives a program image as a byte stream with a valid/ready handshake, assembles little-endian 32-bit words, and writes them into instruction memory through its word-addressed write port.
- Holds the core (fetch unit) via core_hold until a complete, well-formed image has been written.
- Sits between the host/debug byte source and the instruction memory write port.

---
 rtl/instruction_memory_loader_if.sv | 29 ++
 rtl/instruction_memory_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the loader.
// The host or debug byte source drives the master side. The loader takes the slave side.
interface instruction_memory_loader_if #(
  parameter int ADDRESS_WIDTH = 10
);
  logic                     start;
  logic [7:0]               byte_data;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     memory_write_enable;
  logic [ADDRESS_WIDTH-1:0] memory_address;
  logic [31:0]              memory_data_in;
  logic                     core_hold;
  logic                     load_done;
  logic                     load_error;
  logic [ADDRESS_WIDTH:0]   words_written;

  modport master (
    output start, byte_data, byte_valid,
    input  byte_ready, memory_write_enable, memory_address, memory_data_in,
           core_hold, load_done, load_error, words_written
  );

  modport slave (
    input  start, byte_data, byte_valid,
    output byte_ready, memory_write_enable, memory_address, memory_data_in,
           core_hold, load_done, load_error, words_written
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction memory loader.
// The loader receives a program image as a byte stream. The stream starts with a
// 16-bit little-endian word count N, followed by N little-endian 32-bit words.
// Each word goes into instruction memory through a one-cycle write strobe.
// The core stays held until a complete, well-formed image has been written.
module instruction_memory_loader #(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic                        system_clock,
  input logic                        reset,
  instruction_memory_loader_if.slave loader_io
);

  // The timer only has to count up to TIMEOUT_CYCLES-1. Reaching the limit is detected one step early.
  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDRESS_WIDTH);

  typedef enum logic [2:0] {
    IDLE, HEADER_LO, HEADER_HI, PAYLOAD, FLUSH, DONE, ERROR
  } state_t;

  state_t                   state_q;
  logic                     byteReady_q;
  logic                     writeEnable_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [31:0]              dataIn_q;
  logic                     coreHold_q;
  logic                     loadDone_q;
  logic                     loadError_q;
  logic [ADDRESS_WIDTH:0]   wordsWritten_q;
  logic [7:0]               headerLo_q;
  logic [15:0]              wordCount_q;
  logic [23:0]              assembly_q;
  logic [1:0]               byteCount_q;
  logic [TIMER_WIDTH-1:0]   timer_q;

  logic        byteAccepted;
  logic [15:0] headerWord;
  logic        lastWord;
  logic        timeoutHit;

  // byteReady_q is high exactly in the three receiving states, so it also marks "loading".
  // wordsWritten_q doubles as the word index: both clear on start and advance with each strobe.
  assign byteAccepted = loader_io.byte_valid && byteReady_q;
  assign headerWord   = {loader_io.byte_data, headerLo_q};
  assign lastWord     = (17'(wordsWritten_q) + 17'd1) == {1'b0, wordCount_q};
  assign timeoutHit   = (TIMEOUT_CYCLES > 0) && !byteAccepted && (timer_q == TIMER_LAST);

  // Load sequencer: header decode, word assembly, write strobes, timeout and status outputs.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q        <= IDLE;
      byteReady_q    <= 1'b0;
      writeEnable_q  <= 1'b0;
      address_q      <= '0;
      dataIn_q       <= '0;
      coreHold_q     <= 1'b1;
      loadDone_q     <= 1'b0;
      loadError_q    <= 1'b0;
      wordsWritten_q <= '0;
      headerLo_q     <= '0;
      wordCount_q    <= '0;
      assembly_q     <= '0;
      byteCount_q    <= '0;
      timer_q        <= '0;
    end else begin
      writeEnable_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (loader_io.start) begin
            state_q        <= HEADER_LO;
            byteReady_q    <= 1'b1;
            coreHold_q     <= 1'b1;
            loadDone_q     <= 1'b0;
            loadError_q    <= 1'b0;
            wordsWritten_q <= '0;
            assembly_q     <= '0;
            byteCount_q    <= '0;
            timer_q        <= '0;
          end
        end
        HEADER_LO: begin
          if (byteAccepted) begin
            headerLo_q <= loader_io.byte_data;
            state_q    <= HEADER_HI;
          end
        end
        HEADER_HI: begin
          if (byteAccepted) begin
            wordCount_q <= headerWord;
            if (headerWord == 16'd0) begin
              state_q     <= DONE;
              byteReady_q <= 1'b0;
              coreHold_q  <= 1'b0;
              loadDone_q  <= 1'b1;
            end else if (17'(headerWord) > CAPACITY) begin
              state_q     <= ERROR;
              byteReady_q <= 1'b0;
              loadError_q <= 1'b1;
            end else begin
              state_q <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (byteAccepted) begin
            byteCount_q <= byteCount_q + 2'd1;
            case (byteCount_q)
              2'd0: assembly_q[7:0]   <= loader_io.byte_data;
              2'd1: assembly_q[15:8]  <= loader_io.byte_data;
              2'd2: assembly_q[23:16] <= loader_io.byte_data;
              default: begin
                writeEnable_q  <= 1'b1;
                address_q      <= wordsWritten_q[ADDRESS_WIDTH-1:0];
                dataIn_q       <= {loader_io.byte_data, assembly_q};
                wordsWritten_q <= wordsWritten_q + (ADDRESS_WIDTH + 1)'(1);
                if (lastWord) begin
                  state_q     <= FLUSH;
                  byteReady_q <= 1'b0;
                end
              end
            endcase
          end
        end
        FLUSH: begin
          state_q    <= DONE;
          coreHold_q <= 1'b0;
          loadDone_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      if (byteReady_q) begin
        if (byteAccepted) begin
          timer_q <= '0;
        end else if (timeoutHit) begin
          state_q     <= ERROR;
          byteReady_q <= 1'b0;
          loadError_q <= 1'b1;
        end else begin
          timer_q <= timer_q + TIMER_WIDTH'(1);
        end
      end
    end
  end

  assign loader_io.byte_ready          = byteReady_q;
  assign loader_io.memory_write_enable = writeEnable_q;
  assign loader_io.memory_address      = address_q;
  assign loader_io.memory_data_in      = dataIn_q;
  assign loader_io.core_hold           = coreHold_q;
  assign loader_io.load_done           = loadDone_q;
  assign loader_io.load_error          = loadError_q;
  assign loader_io.words_written       = wordsWritten_q;

endmodule
